// File: rtl/cc2420_pkg.sv
`timescale 1ns/1ps
// Shared types and constants for the CC2420 command sequencer.
package cc2420_pkg;

  // Command encodings on CmdType; the reserved code is handled as a strobe.
  typedef enum logic [1:0] {
    CMD_STROBE = 2'b00,
    CMD_WRITE  = 2'b01,
    CMD_READ   = 2'b10,
    CMD_RSVD   = 2'b11
  } cmd_type_t;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SEND    = 2'b01,
    WAIT_RX = 2'b10,
    DONE    = 2'b11
  } state_t;

  // Bit positions inside the header byte.
  localparam logic [2:0] RAM_FLAG_BIT = 3'd7;
  localparam logic [2:0] READ_BIT     = 3'd6;

  // Frame lengths in bytes.
  localparam logic [1:0] STROBE_BYTES = 2'd1;
  localparam logic [1:0] REG_BYTES    = 2'd3;

  // Number of bytes exchanged for a command type.
  function automatic logic [1:0] cmd_byte_count(input cmd_type_t t);
    return ((t == CMD_WRITE) || (t == CMD_READ)) ? REG_BYTES : STROBE_BYTES;
  endfunction

  // Header byte: register-space access, read bit set only for reads.
  function automatic logic [7:0] cmd_header(input cmd_type_t t, input logic [5:0] addr);
    logic [7:0] h;
    h               = {2'b00, addr};
    h[RAM_FLAG_BIT] = 1'b0;
    h[READ_BIT]     = (t == CMD_READ);
    return h;
  endfunction

endpackage

// File: rtl/cc2420_spi_cmd.sv
`timescale 1ns/1ps
// Expands strobe / register-write / register-read commands into CC2420 SPI
// byte frames, feeds them over the byte handshake and gathers the replies.
module cc2420_spi_cmd
  import cc2420_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic        Clock,
  input  logic        Reset_,
  input  logic        CmdValid,
  output logic        CmdReady,
  input  logic [1:0]  CmdType,
  input  logic [5:0]  CmdAddr,
  input  logic [15:0] CmdData,
  output logic        Done,
  output logic [7:0]  Status,
  output logic [15:0] RdData,
  output logic        SPIInValid,
  output logic [7:0]  SPIIn,
  input  logic        SPIInRequest,
  input  logic        SPINewData,
  input  logic [7:0]  SPIOut
);

  // Gap counter holds GAP_CYCLES-1 at most: it is loaded while leaving DONE,
  // so CmdReady rises exactly GAP_CYCLES cycles after the Done cycle.
  localparam int unsigned GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);
  localparam logic [GAP_W-1:0] GAP_LOAD =
    (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

  state_t           state;
  logic [GAP_W-1:0] gap;
  logic [1:0]       tx_idx;
  logic [1:0]       rx_idx;

  // Latched command.
  logic             is_read_q;
  logic [1:0]       nbytes_q;
  logic [7:0]       byte1_q;
  logic [7:0]       byte2_q;

  // Replies collected before the final byte arrives.
  logic [7:0]       rx_status;
  logic [7:0]       rx_hi;

  cmd_type_t        cmd_type;
  logic             accept;
  logic             tx_fire;
  logic             tx_last;
  logic             rx_capture;
  logic [2:0]       rx_cnt_next;
  logic             rx_last;

  // Handshake and completion decode.
  always_comb begin
    cmd_type    = cmd_type_t'(CmdType);
    CmdReady    = (state == IDLE) && (gap == '0);
    accept      = CmdValid && CmdReady;
    tx_fire     = (state == SEND) && SPIInValid && SPIInRequest;
    tx_last     = ({1'b0, tx_idx} + 3'd1) >= {1'b0, nbytes_q};
    rx_capture  = SPINewData && ((state == SEND) || (state == WAIT_RX));
    rx_cnt_next = {1'b0, rx_idx} + 3'd1;
    rx_last     = rx_capture && (state == WAIT_RX) && (rx_cnt_next >= {1'b0, nbytes_q});
  end

  // Sequencer: command latch, byte offer, reply collection and gap timing.
  always_ff @(posedge Clock or negedge Reset_) begin
    if (!Reset_) begin
      state      <= IDLE;
      gap        <= '0;
      tx_idx     <= '0;
      rx_idx     <= '0;
      is_read_q  <= 1'b0;
      nbytes_q   <= STROBE_BYTES;
      byte1_q    <= '0;
      byte2_q    <= '0;
      rx_status  <= '0;
      rx_hi      <= '0;
      SPIInValid <= 1'b0;
      SPIIn      <= '0;
      Done       <= 1'b0;
      Status     <= '0;
      RdData     <= '0;
    end else begin
      Done <= 1'b0;
      if (gap != '0) begin
        gap <= gap - GAP_W'(1);
      end

      // Count returned bytes while a frame is active; rx_idx saturates at 3.
      if (rx_capture) begin
        case (rx_idx)
          2'd0:    rx_status <= SPIOut;
          2'd1:    rx_hi     <= SPIOut;
          default: ;
        endcase
        if (rx_idx != 2'd3) begin
          rx_idx <= rx_idx + 2'd1;
        end
      end

      unique case (state)
        IDLE: begin
          if (accept) begin
            is_read_q  <= (cmd_type == CMD_READ);
            nbytes_q   <= cmd_byte_count(cmd_type);
            byte1_q    <= (cmd_type == CMD_WRITE) ? CmdData[15:8] : 8'h00;
            byte2_q    <= (cmd_type == CMD_WRITE) ? CmdData[7:0]  : 8'h00;
            SPIIn      <= cmd_header(cmd_type, CmdAddr);
            SPIInValid <= 1'b1;
            tx_idx     <= '0;
            rx_idx     <= '0;
            state      <= SEND;
          end
        end

        SEND: begin
          if (tx_fire) begin
            tx_idx <= tx_idx + 2'd1;
            if (tx_last) begin
              SPIInValid <= 1'b0;
              state      <= WAIT_RX;
            end else begin
              SPIIn <= (tx_idx == 2'd0) ? byte1_q : byte2_q;
            end
          end
        end

        WAIT_RX: begin
          // The final reply commits the results so they stay stable until
          // the next completion.
          if (rx_last) begin
            Status <= (rx_idx == 2'd0) ? SPIOut : rx_status;
            if (is_read_q) begin
              RdData <= {rx_hi, SPIOut};
            end
            Done  <= 1'b1;
            state <= DONE;
          end
        end

        DONE: begin
          gap   <= GAP_LOAD;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cc2420_spi_cmd.sv
`timescale 1ns/1ps
// Self-checking bench for cc2420_spi_cmd with a simple SPI engine responder.
module tb_cc2420_spi_cmd;

  localparam int unsigned GAP = 4;

  logic        Clock = 1'b0;
  logic        Reset_ = 1'b0;
  logic        CmdValid = 1'b0;
  logic [1:0]  CmdType = 2'b00;
  logic [5:0]  CmdAddr = 6'h00;
  logic [15:0] CmdData = 16'h0000;
  logic        SPIInRequest = 1'b0;
  logic        SPINewData = 1'b0;
  logic [7:0]  SPIOut = 8'h00;
  logic        CmdReady;
  logic        Done;
  logic [7:0]  Status;
  logic [15:0] RdData;
  logic        SPIInValid;
  logic [7:0]  SPIIn;

  cc2420_spi_cmd #(.GAP_CYCLES(GAP)) dut (
    .Clock(Clock), .Reset_(Reset_),
    .CmdValid(CmdValid), .CmdReady(CmdReady), .CmdType(CmdType),
    .CmdAddr(CmdAddr), .CmdData(CmdData),
    .Done(Done), .Status(Status), .RdData(RdData),
    .SPIInValid(SPIInValid), .SPIIn(SPIIn), .SPIInRequest(SPIInRequest),
    .SPINewData(SPINewData), .SPIOut(SPIOut)
  );

  always #5 Clock = ~Clock;

  int n_cmp = 0;
  int n_bad = 0;
  int edge_n = 0;
  int acc_cnt = 0, acc_edge = 0;
  int done_cnt = 0, done_edge = 0;
  int last_nd_edge = 0, last_due = 0;
  int lat = 2;
  int req_mode = 1;

  logic [7:0]  tx_q[$];
  int          tx_edge_q[$];
  int          due_q[$];
  logic [7:0]  rsp_q[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  exp_status = 8'h00;
  logic [15:0] exp_rd = 16'h0000;

  // Observe handshakes at each rising edge (pre-edge values).
  always @(posedge Clock) begin
    int d;
    edge_n = edge_n + 1;
    if (Reset_) begin
      if (CmdValid && CmdReady) begin
        acc_cnt  = acc_cnt + 1;
        acc_edge = edge_n;
      end
      if (SPIInValid && SPIInRequest) begin
        d = edge_n + lat;
        if (d <= last_due) d = last_due + 1;
        last_due = d;
        tx_q.push_back(SPIIn);
        tx_edge_q.push_back(edge_n);
        due_q.push_back(d);
      end
      if (Done) begin
        done_cnt  = done_cnt + 1;
        done_edge = edge_n;
      end
      if (SPINewData) last_nd_edge = edge_n;
    end
  end

  // SPI engine model: returns one byte per transferred byte, in order.
  always @(negedge Clock) begin
    SPINewData = 1'b0;
    if (due_q.size() > 0 && due_q[0] <= edge_n + 1) begin
      void'(due_q.pop_front());
      SPINewData = 1'b1;
      SPIOut = (rsp_q.size() > 0) ? rsp_q.pop_front() : 8'h00;
    end
    case (req_mode)
      0:       SPIInRequest = 1'b0;
      1:       SPIInRequest = 1'b1;
      default: SPIInRequest = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic cycles(input int n);
    repeat (n) begin @(posedge Clock); #1; end
  endtask

  task automatic clear_logs();
    tx_q.delete(); tx_edge_q.delete(); due_q.delete(); rsp_q.delete();
    last_due = edge_n;
  endtask

  // Reference frame built from the command rules.
  task automatic build_expected(input logic [1:0] t, input logic [5:0] a, input logic [15:0] d);
    exp_q.delete();
    exp_q.push_back({1'b0, (t == 2'b10), a});
    if (t == 2'b01) begin exp_q.push_back(d[15:8]); exp_q.push_back(d[7:0]); end
    if (t == 2'b10) begin exp_q.push_back(8'h00); exp_q.push_back(8'h00); end
  endtask

  task automatic issue_cmd(input logic [1:0] t, input logic [5:0] a, input logic [15:0] d);
    int a0;
    bit ok;
    a0 = acc_cnt; ok = 0;
    CmdValid = 1'b1; CmdType = t; CmdAddr = a; CmdData = d;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(posedge Clock); #1;
      if (acc_cnt != a0) ok = 1;
    end
    CmdValid = 1'b0;
    CmdType = 2'($urandom); CmdAddr = 6'($urandom); CmdData = 16'($urandom);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL accept_timeout: accepted=0 want 1"); end
  endtask

  task automatic wait_done(input int budget);
    int d0;
    bit ok;
    d0 = done_cnt; ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge Clock); #1;
      if (done_cnt != d0) ok = 1;
    end
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL done_timeout: done=0 want 1"); end
  endtask

  task automatic test_reset();
    Reset_ = 1'b0;
    cycles(3);
    n_cmp++; if (SPIInValid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", SPIInValid); end
    n_cmp++; if (SPIIn !== 8'h00) begin n_bad++; $display("FAIL rst_spiin: got %h want 00", SPIIn); end
    n_cmp++; if (Done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", Done); end
    n_cmp++; if (Status !== 8'h00) begin n_bad++; $display("FAIL rst_status: got %h want 00", Status); end
    n_cmp++; if (RdData !== 16'h0000) begin n_bad++; $display("FAIL rst_rddata: got %h want 0000", RdData); end
    @(negedge Clock); Reset_ = 1'b1;
    cycles(1);
    n_cmp++; if (CmdReady !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b want 1", CmdReady); end
  endtask

  task automatic test_strobe(input logic [5:0] a, input logic [7:0] r);
    int d0;
    clear_logs(); lat = 2; req_mode = 1;
    rsp_q.push_back(r);
    build_expected(2'b00, a, 16'h0000);
    d0 = done_cnt;
    issue_cmd(2'b00, a, 16'h0000);
    wait_done(60);
    exp_status = r;
    n_cmp++; if (tx_q.size() != 1) begin n_bad++; $display("FAIL strobe_count: got %0d want 1", tx_q.size()); end
    n_cmp++; if (tx_q.size() > 0 && tx_q[0] !== exp_q[0]) begin n_bad++; $display("FAIL strobe_byte: got %h want %h", tx_q[0], exp_q[0]); end
    n_cmp++; if (done_edge != last_nd_edge + 1) begin n_bad++; $display("FAIL strobe_done_lat: got %0d want %0d", done_edge, last_nd_edge + 1); end
    n_cmp++; if (Status !== exp_status) begin n_bad++; $display("FAIL strobe_status: got %h want %h", Status, exp_status); end
    n_cmp++; if (RdData !== exp_rd) begin n_bad++; $display("FAIL strobe_rddata: got %h want %h", RdData, exp_rd); end
    cycles(6);
    n_cmp++; if (done_cnt != d0 + 1) begin n_bad++; $display("FAIL strobe_done_once: got %0d want %0d", done_cnt - d0, 1); end
  endtask

  task automatic test_write();
    int d0;
    clear_logs(); lat = 3; req_mode = 1;
    rsp_q.push_back(8'h4C); rsp_q.push_back(8'h01); rsp_q.push_back(8'h02);
    build_expected(2'b01, 6'h11, 16'hA55A);
    d0 = done_cnt;
    issue_cmd(2'b01, 6'h11, 16'hA55A);
    n_cmp++; if (SPIInValid !== 1'b1 || SPIIn !== 8'h11) begin n_bad++; $display("FAIL write_first_offer: got %b/%h want 1/11", SPIInValid, SPIIn); end
    wait_done(80);
    exp_status = 8'h4C;
    n_cmp++; if (tx_q.size() != 3) begin n_bad++; $display("FAIL write_count: got %0d want 3", tx_q.size()); end
    for (int i = 0; i < 3 && i < tx_q.size(); i++) begin
      n_cmp++; if (tx_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL write_byte%0d: got %h want %h", i, tx_q[i], exp_q[i]); end
    end
    for (int i = 1; i < tx_edge_q.size(); i++) begin
      n_cmp++; if (tx_edge_q[i] != tx_edge_q[i-1] + 1) begin n_bad++; $display("FAIL write_b2b%0d: gap %0d want 1", i, tx_edge_q[i] - tx_edge_q[i-1]); end
    end
    n_cmp++; if (Status !== exp_status) begin n_bad++; $display("FAIL write_status: got %h want %h", Status, exp_status); end
    n_cmp++; if (RdData !== exp_rd) begin n_bad++; $display("FAIL write_rddata: got %h want %h", RdData, exp_rd); end
    cycles(6);
    n_cmp++; if (done_cnt != d0 + 1) begin n_bad++; $display("FAIL write_done_once: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_read();
    clear_logs(); lat = 4; req_mode = 1;
    rsp_q.push_back(8'h42); rsp_q.push_back(8'h12); rsp_q.push_back(8'h34);
    build_expected(2'b10, 6'h1D, 16'h0000);
    issue_cmd(2'b10, 6'h1D, 16'hFFFF);
    wait_done(80);
    exp_status = 8'h42; exp_rd = 16'h1234;
    n_cmp++; if (tx_q.size() != 3) begin n_bad++; $display("FAIL read_count: got %0d want 3", tx_q.size()); end
    for (int i = 0; i < 3 && i < tx_q.size(); i++) begin
      n_cmp++; if (tx_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL read_byte%0d: got %h want %h", i, tx_q[i], exp_q[i]); end
    end
    n_cmp++; if (done_edge != last_nd_edge + 1) begin n_bad++; $display("FAIL read_done_lat: got %0d want %0d", done_edge, last_nd_edge + 1); end
    n_cmp++; if (Status !== exp_status) begin n_bad++; $display("FAIL read_status: got %h want %h", Status, exp_status); end
    n_cmp++; if (RdData !== exp_rd) begin n_bad++; $display("FAIL read_rddata: got %h want %h", RdData, exp_rd); end
  endtask

  task automatic test_backpressure();
    int d0;
    clear_logs(); lat = 2; req_mode = 0;
    rsp_q.push_back(8'h5E); rsp_q.push_back(8'h00); rsp_q.push_back(8'h00);
    build_expected(2'b01, 6'h22, 16'hBEEF);
    d0 = done_cnt;
    issue_cmd(2'b01, 6'h22, 16'hBEEF);
    for (int i = 0; i < 20; i++) begin
      n_cmp++; if (SPIInValid !== 1'b1 || SPIIn !== 8'h22) begin n_bad++; $display("FAIL bp_hold%0d: got %b/%h want 1/22", i, SPIInValid, SPIIn); end
      cycles(1);
    end
    n_cmp++; if (done_cnt != d0 || tx_q.size() != 0) begin n_bad++; $display("FAIL bp_idle: done %0d tx %0d want 0 0", done_cnt - d0, tx_q.size()); end
    req_mode = 1;
    wait_done(80);
    exp_status = 8'h5E;
    n_cmp++; if (tx_q.size() != 3 || tx_q[2] !== 8'hEF) begin n_bad++; $display("FAIL bp_frame: got %0d bytes want 3 ending EF", tx_q.size()); end
    n_cmp++; if (Status !== exp_status) begin n_bad++; $display("FAIL bp_status: got %h want %h", Status, exp_status); end
  endtask

  task automatic test_back_to_back();
    int a0, d1;
    bit ok;
    clear_logs(); lat = 2; req_mode = 1;
    rsp_q.push_back(8'h11); rsp_q.push_back(8'h22);
    a0 = acc_cnt;
    CmdValid = 1'b1; CmdType = 2'b00; CmdAddr = 6'h02; CmdData = 16'h0000;
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin cycles(1); if (acc_cnt != a0) ok = 1; end
    wait_done(60);
    d1 = done_edge;
    n_cmp++; if (acc_cnt != a0 + 1) begin n_bad++; $display("FAIL b2b_busy_accepts: got %0d want 1", acc_cnt - a0); end
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin cycles(1); if (acc_cnt != a0 + 1) ok = 1; end
    CmdValid = 1'b0;
    n_cmp++; if (acc_edge != d1 + GAP) begin n_bad++; $display("FAIL b2b_gap: accept at %0d want %0d", acc_edge, d1 + GAP); end
    wait_done(60);
    exp_status = 8'h22;
    n_cmp++; if (tx_q.size() != 2) begin n_bad++; $display("FAIL b2b_count: got %0d want 2", tx_q.size()); end
    n_cmp++; if (Status !== exp_status) begin n_bad++; $display("FAIL b2b_status: got %h want %h", Status, exp_status); end
  endtask

  task automatic test_ignore_pulse();
    int a0, d0;
    clear_logs(); lat = 5; req_mode = 1;
    rsp_q.push_back(8'h33);
    a0 = acc_cnt; d0 = done_cnt;
    issue_cmd(2'b00, 6'h03, 16'h0000);
    cycles(1);
    CmdValid = 1'b1; CmdType = 2'b10; CmdAddr = 6'h3F;
    cycles(1);
    CmdValid = 1'b0;
    wait_done(60);
    CmdValid = 1'b1; CmdType = 2'b01; CmdAddr = 6'h3E;
    cycles(1);
    CmdValid = 1'b0;
    cycles(8);
    exp_status = 8'h33;
    n_cmp++; if (acc_cnt != a0 + 1) begin n_bad++; $display("FAIL pulse_accepts: got %0d want 1", acc_cnt - a0); end
    n_cmp++; if (tx_q.size() != 1 || tx_q[0] !== 8'h03) begin n_bad++; $display("FAIL pulse_frame: got %0d bytes want 1 (03)", tx_q.size()); end
    n_cmp++; if (done_cnt != d0 + 1) begin n_bad++; $display("FAIL pulse_done: got %0d want 1", done_cnt - d0); end
    n_cmp++; if (Status !== exp_status) begin n_bad++; $display("FAIL pulse_status: got %h want %h", Status, exp_status); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 25; it++) begin
      logic [1:0]  t;
      logic [5:0]  a;
      logic [15:0] d;
      logic [7:0]  r0, r1, r2;
      int          nb;
      t = 2'($urandom); a = 6'($urandom); d = 16'($urandom);
      r0 = 8'($urandom); r1 = 8'($urandom); r2 = 8'($urandom);
      nb = (t == 2'b01 || t == 2'b10) ? 3 : 1;
      clear_logs(); lat = $urandom_range(1, 6); req_mode = 2;
      rsp_q.push_back(r0);
      if (nb == 3) begin rsp_q.push_back(r1); rsp_q.push_back(r2); end
      build_expected(t, a, d);
      issue_cmd(t, a, d);
      wait_done(200);
      exp_status = r0;
      if (t == 2'b10) exp_rd = {r1, r2};
      n_cmp++; if (tx_q.size() != exp_q.size()) begin n_bad++; $display("FAIL rnd%0d_count: got %0d want %0d", it, tx_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < tx_q.size(); i++) begin
        n_cmp++; if (tx_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL rnd%0d_byte%0d: got %h want %h", it, i, tx_q[i], exp_q[i]); end
      end
      n_cmp++; if (Status !== exp_status) begin n_bad++; $display("FAIL rnd%0d_status: got %h want %h", it, Status, exp_status); end
      n_cmp++; if (RdData !== exp_rd) begin n_bad++; $display("FAIL rnd%0d_rddata: got %h want %h", it, RdData, exp_rd); end
    end
    req_mode = 1;
    cycles(GAP + 2);
  endtask

  task automatic test_reset_mid();
    int d0;
    clear_logs(); lat = 12; req_mode = 1;
    rsp_q.push_back(8'h77); rsp_q.push_back(8'h00); rsp_q.push_back(8'h00);
    d0 = done_cnt;
    issue_cmd(2'b01, 6'h11, 16'hA55A);
    cycles(1);
    n_cmp++; if (SPIInValid !== 1'b1 || SPIIn !== 8'hA5) begin n_bad++; $display("FAIL rmid_second: got %b/%h want 1/a5", SPIInValid, SPIIn); end
    #2 Reset_ = 1'b0;
    #1;
    n_cmp++; if (SPIInValid !== 1'b0) begin n_bad++; $display("FAIL rmid_async_valid: got %b want 0", SPIInValid); end
    clear_logs();
    exp_status = 8'h00; exp_rd = 16'h0000;
    cycles(2);
    @(negedge Clock); Reset_ = 1'b1;
    cycles(15);
    n_cmp++; if (CmdReady !== 1'b1) begin n_bad++; $display("FAIL rmid_ready: got %b want 1", CmdReady); end
    n_cmp++; if (done_cnt != d0) begin n_bad++; $display("FAIL rmid_no_done: got %0d want 0", done_cnt - d0); end
    n_cmp++; if (Status !== exp_status || RdData !== exp_rd) begin n_bad++; $display("FAIL rmid_regs: got %h/%h want %h/%h", Status, RdData, exp_status, exp_rd); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_strobe(6'h08, 8'h40);
    test_write();
    test_read();
    test_backpressure();
    test_back_to_back();
    test_ignore_pulse();
    test_random();
    test_reset_mid();
    test_strobe(6'h08, 8'h40);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
